// File: rtl/tx_fifo_arb_pkg.sv
// rtl/tx_fifo_arb_pkg.sv - shared types and helpers for the tx_fifo_arb block
//   state_e : arbiter FSM states (IDLE, BUSY)
//   rr_next : next round-robin index, wrapping at nreq-1 back to 0
package tx_fifo_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned nreq);
        return (idx + 1 >= nreq) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/tx_fifo_arb_rr_arbiter.sv
// rtl/tx_fifo_arb_rr_arbiter.sv - combinational round-robin pick starting after the last winner
//   req_i       : request vector, one bit per requester
//   last_i      : index of the previous winner
//   gnt_oh_o    : one-hot grant
//   gnt_idx_o   : grant index
//   gnt_valid_o : at least one request present
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] last_i,
    output logic [NREQ-1:0] gnt_oh_o,
    output logic [IDXW-1:0] gnt_idx_o,
    output logic            gnt_valid_o
);
    import tx_fifo_arb_pkg::*;

    // Walk the ring once, beginning just after the previous winner; the
    // first requesting port met wins, so idle ports are skipped naturally.
    always_comb begin
        int unsigned cand;
        gnt_oh_o    = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        cand        = rr_next(32'(last_i), NREQ);
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_valid_o && req_i[IDXW'(cand)]) begin
                gnt_valid_o              = 1'b1;
                gnt_idx_o                = IDXW'(cand);
                gnt_oh_o[IDXW'(cand)]    = 1'b1;
            end
            cand = rr_next(cand, NREQ);
        end
    end

endmodule

// File: rtl/tx_fifo_arb.sv
// rtl/tx_fifo_arb.sv - round-robin packet arbiter feeding the write side of a FIFO
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/data/last  : per-requester word stream (requester i at data[i*DATA_W +: DATA_W])
//   req_ready            : per-requester accept
//   fifo_wdata/wen       : FIFO write port
//   fifo_wfull/wload     : FIFO write-side full flag and fill level
//   gnt_id, busy         : current/last granted requester, grant held
//   Optional macro TX_FIFO_ARB_SPACE_CHECK_EN: grant only when a full burst fits in the FIFO.
module tx_fifo_arb #(
    parameter int NREQ        = 4,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 10,
    parameter int WORDS_TOTAL = 2**ADDR_W,
    parameter int BURST_MAX   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic [DATA_W-1:0]        fifo_wdata,
    output logic                     fifo_wen,
    input  logic                     fifo_wfull,
    input  logic [ADDR_W:0]          fifo_wload,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic                     busy
);
    import tx_fifo_arb_pkg::*;

    localparam int IDXW = $clog2(NREQ);
    localparam int CNTW = $clog2(BURST_MAX + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BURST_MAX - 1);

    state_e          state_q, state_d;
    logic [IDXW-1:0] gnt_q, gnt_d;
    logic [IDXW-1:0] last_q, last_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    // Forces one IDLE cycle with no arbitration right after a burst ends.
    logic            cool_q, cool_d;

    logic [NREQ-1:0] gnt_oh_unused;
    logic [IDXW-1:0] win_idx;
    logic            win_valid;
    logic            eligible;
    logic            in_busy;
    logic            xfer;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_arbiter (
        .req_i       (req_valid),
        .last_i      (last_q),
        .gnt_oh_o    (gnt_oh_unused),
        .gnt_idx_o   (win_idx),
        .gnt_valid_o (win_valid)
    );

`ifdef TX_FIFO_ARB_SPACE_CHECK_EN
    localparam logic [ADDR_W:0] WORDS_TOTAL_W = (ADDR_W+1)'(WORDS_TOTAL);
    localparam logic [ADDR_W:0] BURST_MAX_W   = (ADDR_W+1)'(BURST_MAX);
    logic [ADDR_W:0] space;
    assign space    = WORDS_TOTAL_W - fifo_wload;
    assign eligible = win_valid && (space >= BURST_MAX_W);
`else
    logic wload_unused;
    assign wload_unused = ^fifo_wload;
    assign eligible     = win_valid && !fifo_wfull;
`endif

    // Outputs are gated by rst so nothing is accepted or written in the reset cycle.
    assign in_busy    = (state_q == ST_BUSY) && !rst;
    assign xfer       = in_busy && req_valid[gnt_q] && !fifo_wfull;
    assign fifo_wen   = xfer;
    assign fifo_wdata = req_data[gnt_q*DATA_W +: DATA_W];
    assign busy       = in_busy;
    assign gnt_id     = rst ? '0 : gnt_q;

    always_comb begin
        req_ready = '0;
        if (in_busy && !fifo_wfull) begin
            req_ready[gnt_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        cool_d  = cool_q;
        case (state_q)
            ST_IDLE: begin
                if (cool_q) begin
                    cool_d = 1'b0;
                end else if (eligible) begin
                    state_d = ST_BUSY;
                    gnt_d   = win_idx;
                    last_d  = win_idx;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                // A stalled or idle cycle holds both the counter and the grant.
                if (xfer) begin
                    cnt_d = cnt_q + CNTW'(1);
                    if (req_last[gnt_q] || (cnt_q == CNT_LAST)) begin
                        state_d = ST_IDLE;
                        cool_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= IDXW'(NREQ - 1);
            cnt_q   <= '0;
            cool_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            cool_q  <= cool_d;
        end
    end

endmodule

// File: tb/tb_tx_fifo_arb.sv
// tb/tb_tx_fifo_arb.sv - self-checking bench for tx_fifo_arb with a write-side scoreboard
module tb_tx_fifo_arb;

    localparam int NREQ        = 4;
    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 10;
    localparam int WORDS_TOTAL = 1024;
    localparam int BURST_MAX   = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_ready;
    logic [DATA_W-1:0]      fifo_wdata;
    logic                   fifo_wen;
    logic                   fifo_wfull;
    logic [ADDR_W:0]        fifo_wload;
    logic [1:0]             gnt_id;
    logic                   busy;

    int errors = 0;
    int checks = 0;

    logic [8:0]  src_mem [NREQ][256];
    int          src_rd [NREQ];
    int          src_wr [NREQ];
    logic [7:0]  exp_q [$];
    logic [1:0]  gnt_log [$];
    int          len_log [$];
    int          wr_cyc [$];
    int          wr_cnt = 0;
    int          cyc = 0;
    int          burst_len = 0;
    logic [NREQ-1:0] acc = '0;
    logic        prev_busy = 1'b0;
    logic [1:0]  prev_gnt = '0;

    tx_fifo_arb #(
        .NREQ        (NREQ),
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .WORDS_TOTAL (WORDS_TOTAL),
        .BURST_MAX   (BURST_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_wdata (fifo_wdata),
        .fifo_wen   (fifo_wen),
        .fifo_wfull (fifo_wfull),
        .fifo_wload (fifo_wload),
        .gnt_id     (gnt_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Requester models: pop on acceptance seen at the previous negedge, present next head.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] && src_rd[i] < src_wr[i]) src_rd[i]++;
                if (src_rd[i] < src_wr[i]) begin
                    req_valid[i]          = 1'b1;
                    req_last[i]           = src_mem[i][src_rd[i]][8];
                    req_data[i*DATA_W +: DATA_W] = src_mem[i][src_rd[i]][7:0];
                end else begin
                    req_valid[i]          = 1'b0;
                    req_last[i]           = 1'b0;
                    req_data[i*DATA_W +: DATA_W] = '0;
                end
            end
        end
    end

    // Write-side monitor and scoreboard.
    initial begin
        logic [7:0] d;
        logic [NREQ-1:0] rdy_exp;
        forever begin
            @(negedge clk);
            cyc++;
            acc = req_valid & req_ready;
            if (busy && !prev_busy) begin
                gnt_log.push_back(gnt_id);
                burst_len = 0;
            end
            if (!busy && prev_busy) len_log.push_back(burst_len);
            if (fifo_wfull) begin
                checks++;
                if (fifo_wen !== 1'b0) begin
                    errors++;
                    $display("FAIL wen_while_full: wen=%b required 0", fifo_wen);
                end
            end
            if (fifo_wen === 1'b1) begin
                wr_cnt++;
                burst_len++;
                wr_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: data=%0h with empty scoreboard", fifo_wdata);
                end else begin
                    d = exp_q.pop_front();
                    if (fifo_wdata !== d) begin
                        errors++;
                        $display("FAIL write_data: got %0h required %0h", fifo_wdata, d);
                    end
                end
            end
            checks++;
            if (!busy) begin
                if (req_ready !== '0 || fifo_wen !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs: ready=%b wen=%b required 0000/0", req_ready, fifo_wen);
                end
            end else begin
                rdy_exp = fifo_wfull ? '0 : (4'b0001 << gnt_id);
                if (req_ready !== rdy_exp) begin
                    errors++;
                    $display("FAIL busy_ready: ready=%b required %b", req_ready, rdy_exp);
                end
            end
            if (busy && prev_busy) begin
                checks++;
                if (gnt_id !== prev_gnt) begin
                    errors++;
                    $display("FAIL gnt_stable: gnt_id=%0d changed from %0d while busy", gnt_id, prev_gnt);
                end
            end
            prev_busy = busy;
            prev_gnt  = gnt_id;
        end
    end

    task automatic flush_src();
        for (int i = 0; i < NREQ; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        len_log.delete();
        wr_cyc.delete();
        wr_cnt = 0;
    endtask

    task automatic load_pkt(input int id, input int len);
        for (int k = 0; k < len; k++) begin
            logic [7:0] d;
            d = 8'($urandom);
            src_mem[id][src_wr[id]] = {(k == len - 1), d};
            src_wr[id]++;
            exp_q.push_back(d);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        flush_src();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (t >= 2000) begin
            errors++;
            $display("FAIL %s_drain: %0d words still expected after %0d cycles", name, exp_q.size(), t);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt_id !== 2'd0 || req_ready !== '0 || fifo_wen !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b gnt=%0d ready=%b wen=%b required 0/0/0000/0",
                     busy, gnt_id, req_ready, fifo_wen);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL post_reset: busy=%b gnt=%0d required 0/0", busy, gnt_id);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] g_exp [5];
        g_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        load_pkt(0, 3);
        load_pkt(1, 3);
        load_pkt(2, 3);
        load_pkt(3, 3);
        load_pkt(0, 3);
        wait_drain("rr");
        checks++;
        if (gnt_log.size() != 5) begin
            errors++;
            $display("FAIL rr_grant_count: got %0d required 5", gnt_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (gnt_log[i] !== g_exp[i]) begin
                    errors++;
                    $display("FAIL rr_grant_%0d: got %0d required %0d", i, gnt_log[i], g_exp[i]);
                end
            end
        end
        checks++;
        if (len_log.size() != 5 || wr_cnt != 15) begin
            errors++;
            $display("FAIL rr_lengths: bursts=%0d writes=%0d required 5/15", len_log.size(), wr_cnt);
        end
    endtask

    task automatic test_burst_max();
        do_reset();
        load_pkt(2, 100);
        wait_drain("burst");
        checks++;
        if (len_log.size() != 2 || len_log[0] != 64 || len_log[1] != 36) begin
            errors++;
            $display("FAIL burst_split: %0d bursts first=%0d required 2 bursts 64+36",
                     len_log.size(), (len_log.size() > 0) ? len_log[0] : -1);
        end
        checks++;
        if (gnt_log.size() != 2 || gnt_log[0] !== 2'd2 || gnt_log[1] !== 2'd2) begin
            errors++;
            $display("FAIL burst_regrant: %0d grants required 2 grants to requester 2", gnt_log.size());
        end
    endtask

    task automatic test_wfull_stall();
        int t = 0;
        do_reset();
        load_pkt(1, 70);
        while (wr_cnt < 3 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        fifo_wfull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_wen !== 1'b0 || req_ready !== '0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_cycle_%0d: wen=%b ready=%b busy=%b required 0/0000/1",
                         i, fifo_wen, req_ready, busy);
            end
        end
        @(posedge clk);
        #1;
        fifo_wfull = 1'b0;
        wait_drain("stall");
        checks++;
        if (len_log.size() != 2 || len_log[0] != 64 || len_log[1] != 6) begin
            errors++;
            $display("FAIL stall_counter: %0d bursts first=%0d required 64+6",
                     len_log.size(), (len_log.size() > 0) ? len_log[0] : -1);
        end
    endtask

    task automatic test_reset_mid_burst();
        int t = 0;
        do_reset();
        load_pkt(1, 5);
        while (wr_cnt < 1 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fifo_wen !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: busy=%b wen=%b ready=%b required 0/0/0000", busy, fifo_wen, req_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush_src();
        exp_q.delete();
        clear_logs();
        load_pkt(0, 1);
        load_pkt(1, 1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_busy: busy=%b required 0", busy);
        end
        wait_drain("midrst");
        checks++;
        if (gnt_log.size() != 2 || gnt_log[0] !== 2'd0 || gnt_log[1] !== 2'd1) begin
            errors++;
            $display("FAIL midrst_first_grant: %0d grants first=%0d required 0 then 1",
                     gnt_log.size(), (gnt_log.size() > 0) ? gnt_log[0] : 2'd3);
        end
    endtask

    task automatic test_single_requester();
        do_reset();
        load_pkt(3, 1);
        load_pkt(3, 1);
        load_pkt(3, 1);
        wait_drain("single");
        checks++;
        if (gnt_log.size() != 3 || gnt_log[0] !== 2'd3 || gnt_log[1] !== 2'd3 || gnt_log[2] !== 2'd3) begin
            errors++;
            $display("FAIL single_grants: %0d grants required 3 grants to requester 3", gnt_log.size());
        end
        checks++;
        if (wr_cyc.size() != 3) begin
            errors++;
            $display("FAIL single_writes: got %0d required 3", wr_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (wr_cyc[i] - wr_cyc[i-1] != 3) begin
                    errors++;
                    $display("FAIL single_period_%0d: got %0d cycles required 3", i, wr_cyc[i] - wr_cyc[i-1]);
                end
            end
        end
    endtask

`ifdef TX_FIFO_ARB_SPACE_CHECK_EN
    task automatic test_space_check();
        do_reset();
        fifo_wload = 11'(WORDS_TOTAL - 63);
        load_pkt(0, 2);
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt_log.size() != 0) begin
            errors++;
            $display("FAIL space_no_grant: busy=%b grants=%0d required 0/0", busy, gnt_log.size());
        end
        @(posedge clk);
        #1;
        fifo_wload = 11'(WORDS_TOTAL - 64);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL space_latency: busy=%b required 0", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL space_grant: busy=%b required 1", busy);
        end
        wait_drain("space");
        fifo_wload = '0;
    endtask
`endif

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        fifo_wfull = 1'b0;
        fifo_wload = '0;
        flush_src();
        test_reset();
        test_round_robin();
        test_burst_max();
        test_wfull_stall();
        test_reset_mid_burst();
        test_single_requester();
`ifdef TX_FIFO_ARB_SPACE_CHECK_EN
        test_space_check();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
